clk_div: RTL and testbench

- Parameterised clock divider producing the slow 1 Hz timebase used by the traffic-light controller's sequencing logic.
- Derives a 50 %-duty square wave from the board clock.
- Also provides a single-cycle enable pulse, aligned to the rising edge of the divided clock, for logic that stays in the fast clock domain.

---
 rtl/clk_div.sv | 43 ++++
 tb/tb_clk_div.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div.sv
// Divides the board clock down to a 50 %-duty timebase and emits a one-cycle
// enable on each rising edge of that timebase for fast-domain consumers.
module clk_div #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int OUT_FREQ_HZ = 1
) (
    input  logic clk,
    input  logic reset,
    output logic clk1hz,
    output logic tick1hz
);

    localparam int HALF = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    generate
        if (HALF < 1) begin : g_bad_ratio
            $fatal(1, "clk_div: CLK_FREQ_HZ too low for OUT_FREQ_HZ (HALF < 1)");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // clk1hz and tick1hz come straight from flops so the consumer sees a glitch-free clock.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk1hz  <= 1'b0;
            tick1hz <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            clk1hz  <= ~clk1hz;
            tick1hz <= ~clk1hz;
        end else begin
            cnt     <= cnt + 1'b1;
            tick1hz <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: three instances cover HALF=5, HALF=1 and the
// truncated HALF=3 ratio, each held in reset while another is exercised.
module tb_clk_div;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic reset_c = 1'b1;
    logic clk1hz_a, tick1hz_a;
    logic clk1hz_b, tick1hz_b;
    logic clk1hz_c, tick1hz_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) dut_a (
        .clk(clk), .reset(reset_a), .clk1hz(clk1hz_a), .tick1hz(tick1hz_a)
    );
    clk_div #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut_b (
        .clk(clk), .reset(reset_b), .clk1hz(clk1hz_b), .tick1hz(tick1hz_b)
    );
    clk_div #(.CLK_FREQ_HZ(7), .OUT_FREQ_HZ(1)) dut_c (
        .clk(clk), .reset(reset_c), .clk1hz(clk1hz_c), .tick1hz(tick1hz_c)
    );

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after the k-th edge following reset release.
    function automatic logic exp_clk(input int k, input int half);
        return ((k / half) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int k, input int half);
        return (k % (2 * half)) == half;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (clk1hz_a !== 1'b0 || tick1hz_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: got clk1hz=%b tick1hz=%b, want 0 0", clk1hz_a, tick1hz_a);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (clk1hz_a !== 1'b0 || tick1hz_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got clk1hz=%b tick1hz=%b, want 0 0", i, clk1hz_a, tick1hz_a);
            end
        end
    endtask

    task automatic test_period();
        int ticks = 0;
        int highs = 0;
        int last_rise = -1;
        logic prev = 1'b0;
        @(negedge clk);
        reset_a = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++;
            if (clk1hz_a !== exp_clk(k, 5) || tick1hz_a !== exp_tick(k, 5)) begin
                errors++;
                $display("FAIL half5_edge%0d: got clk1hz=%b tick1hz=%b, want %b %b",
                         k, clk1hz_a, tick1hz_a, exp_clk(k, 5), exp_tick(k, 5));
            end
            if (tick1hz_a === 1'b1) ticks++;
            if (clk1hz_a === 1'b1) highs++;
            if (clk1hz_a === 1'b1 && prev === 1'b0) begin
                if (last_rise >= 0) begin
                    checks++;
                    if (k - last_rise != 10) begin
                        errors++;
                        $display("FAIL half5_period: got %0d cycles, want 10", k - last_rise);
                    end
                end
                last_rise = k;
            end
            prev = clk1hz_a;
        end
        checks++;
        if (ticks != 4) begin
            errors++;
            $display("FAIL half5_tick_count: got %0d, want 4", ticks);
        end
        checks++;
        if (highs != 20) begin
            errors++;
            $display("FAIL half5_high_cycles: got %0d, want 20", highs);
        end
    endtask

    task automatic test_async_reset();
        // Restart cleanly, then run 8 edges: clk1hz high with internal count at 3.
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        checks++;
        if (clk1hz_a !== 1'b1) begin
            errors++;
            $display("FAIL async_precondition: got clk1hz=%b, want 1", clk1hz_a);
        end
        #2;
        reset_a = 1'b1;
        #1;
        checks++;
        if (clk1hz_a !== 1'b0 || tick1hz_a !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: got clk1hz=%b tick1hz=%b, want 0 0", clk1hz_a, tick1hz_a);
        end
        step();
        checks++;
        if (clk1hz_a !== 1'b0 || tick1hz_a !== 1'b0) begin
            errors++;
            $display("FAIL async_hold: got clk1hz=%b tick1hz=%b, want 0 0", clk1hz_a, tick1hz_a);
        end
        @(negedge clk);
        reset_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (clk1hz_a !== exp_clk(k, 5) || tick1hz_a !== exp_tick(k, 5)) begin
                errors++;
                $display("FAIL async_restart_edge%0d: got clk1hz=%b tick1hz=%b, want %b %b",
                         k, clk1hz_a, tick1hz_a, exp_clk(k, 5), exp_tick(k, 5));
            end
        end
        @(negedge clk);
        reset_a = 1'b1;
    endtask

    task automatic test_half_one();
        @(negedge clk);
        reset_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (clk1hz_b !== exp_clk(k, 1) || tick1hz_b !== exp_tick(k, 1)) begin
                errors++;
                $display("FAIL half1_edge%0d: got clk1hz=%b tick1hz=%b, want %b %b",
                         k, clk1hz_b, tick1hz_b, exp_clk(k, 1), exp_tick(k, 1));
            end
        end
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_truncated();
        int highs = 0;
        @(negedge clk);
        reset_c = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            checks++;
            if (clk1hz_c !== exp_clk(k, 3) || tick1hz_c !== exp_tick(k, 3)) begin
                errors++;
                $display("FAIL half3_edge%0d: got clk1hz=%b tick1hz=%b, want %b %b",
                         k, clk1hz_c, tick1hz_c, exp_clk(k, 3), exp_tick(k, 3));
            end
            if (clk1hz_c === 1'b1) highs++;
        end
        checks++;
        if (highs != 9) begin
            errors++;
            $display("FAIL half3_high_cycles: got %0d, want 9", highs);
        end
        @(negedge clk);
        reset_c = 1'b1;
    endtask

    initial begin
        test_reset();
        test_period();
        test_async_reset();
        test_half_one();
        test_truncated();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
